// File: rtl/dpram_stream_pkg.sv
// Shared definitions for the DPRAM stream reader: default geometry and FSM states.
//   DEF_DATA_W / DEF_ADDR_W / DEF_DEPTH : default RAM word width, address width, valid depth
//   state_e                             : burst sequencer states
package dpram_stream_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DEPTH  = 10;

  // Occupancy counter width of the 2-entry output buffer (0..2).
  localparam int unsigned FIFO_CNT_W = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    FIN   = 2'd3
  } state_e;

endpackage

// File: rtl/stream_skid_fifo.sv
// Two-entry buffer between the RAM read return and the output stream.
// Entry 0 is always the head, so head_data is a plain register output.
//   clk, rst        : clock, synchronous active-high reset
//   push, push_data : write a word (ignored when full and not popping)
//   pop             : remove the head word (ignored when empty)
//   full, empty     : registered occupancy flags
//   count           : current occupancy (0..2)
//   head_data       : word at the head of the buffer
module stream_skid_fifo
  import dpram_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_W-1:0]     push_data,
  input  logic                  pop,
  output logic                  full,
  output logic                  empty,
  output logic [FIFO_CNT_W-1:0] count,
  output logic [DATA_W-1:0]     head_data
);

  logic [DATA_W-1:0]     e0_q, e0_d;
  logic [DATA_W-1:0]     e1_q, e1_d;
  logic [FIFO_CNT_W-1:0] cnt_q, cnt_d;
  logic                  full_q, full_d;
  logic                  empty_q, empty_d;
  logic                  do_push, do_pop;

  // Next-state: shift entry 1 into the head on pop, land pushes in the first free slot.
  always_comb begin
    e0_d    = e0_q;
    e1_d    = e1_q;
    cnt_d   = cnt_q;
    do_pop  = pop && (cnt_q != '0);
    do_push = push && ((cnt_q != FIFO_CNT_W'(2)) || do_pop);
    unique case ({do_push, do_pop})
      2'b10: begin
        if (cnt_q == '0) e0_d = push_data;
        else             e1_d = push_data;
        cnt_d = cnt_q + FIFO_CNT_W'(1);
      end
      2'b01: begin
        e0_d  = e1_q;
        cnt_d = cnt_q - FIFO_CNT_W'(1);
      end
      2'b11: begin
        if (cnt_q == FIFO_CNT_W'(1)) begin
          e0_d = push_data;
        end else begin
          e0_d = e1_q;
          e1_d = push_data;
        end
      end
      default: ;
    endcase
    full_d  = (cnt_d == FIFO_CNT_W'(2));
    empty_d = (cnt_d == '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      e0_q    <= '0;
      e1_q    <= '0;
      cnt_q   <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
    end else begin
      e0_q    <= e0_d;
      e1_q    <= e1_d;
      cnt_q   <= cnt_d;
      full_q  <= full_d;
      empty_q <= empty_d;
    end
  end

  assign full      = full_q;
  assign empty     = empty_q;
  assign count     = cnt_q;
  assign head_data = e0_q;

endmodule

// File: rtl/dpram_stream_reader.sv
// Burst reader: streams len consecutive words of a synchronous-read RAM (read
// latency 1) out on a valid/ready interface, wrapping addresses at DEPTH.
//   clk, rst            : clock, synchronous active-high reset
//   start, base, len    : burst request (accepted only when idle)
//   busy, done          : burst in progress / one-cycle completion pulse
//   rd_en, rd_addr      : RAM read port request (rd_en is combinational)
//   rd_data             : RAM read data, one cycle after rd_en
//   out_valid/ready/data: output stream
//   out_last            : final word marker, present only with DPRAM_STREAM_READER_LAST_EN
module dpram_stream_reader
  import dpram_stream_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base,
  input  logic [ADDR_W:0]   len,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data
`ifdef DPRAM_STREAM_READER_LAST_EN
  ,
  output logic              out_last
`endif
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

  state_e               state_q, state_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [LEN_W-1:0]     rem_q, rem_d;
  logic                 rv_q, rv_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;

  logic                  fifo_full, fifo_empty;
  logic [FIFO_CNT_W-1:0] fifo_count;
  logic [DATA_W-1:0]     fifo_head;

  logic                 out_pop_c;
  logic                 rd_en_c;
  logic [2:0]           pipe_use_c;

  stream_skid_fifo #(
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rv_q),
    .push_data (rd_data),
    .pop       (out_pop_c),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count),
    .head_data (fifo_head)
  );

  // Read credit: words that will still occupy the buffer next cycle (after this
  // cycle's pop, including the word returning now) must leave room for one more.
  always_comb begin
    out_pop_c  = !fifo_empty && out_ready;
    pipe_use_c = 3'(fifo_count) - 3'(out_pop_c) + 3'(rv_q);
    rd_en_c    = (state_q == RUN) && (rem_q != '0) && (pipe_use_c < 3'd2) &&
                 !(fifo_full && !out_pop_c);
  end

  // Burst sequencer next-state and registered status.
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    rem_d   = rem_q;
    rv_d    = rd_en_c;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          // Out-of-range bases fold back into the valid window.
          addr_d  = (base > LAST_ADDR) ? (base - DEPTH_A) : base;
          rem_d   = len;
          state_d = (len == '0) ? FIN : RUN;
        end
      end
      RUN: begin
        if (rd_en_c) begin
          addr_d = (addr_q == LAST_ADDR) ? '0 : (addr_q + ADDR_W'(1));
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN: begin
        if (pipe_use_c == 3'd0) state_d = FIN;
      end
      FIN: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d == RUN) || (state_d == DRAIN);
    done_d = (state_d == FIN);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      rv_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      rv_q    <= rv_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign rd_en     = rd_en_c;
  assign rd_addr   = addr_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_head;

`ifdef DPRAM_STREAM_READER_LAST_EN
  // Words still to be handed to the sink; the head is last when one remains.
  logic [LEN_W-1:0] out_rem_q, out_rem_d;

  always_comb begin
    out_rem_d = out_rem_q;
    if ((state_q == IDLE) && start) out_rem_d = len;
    else if (out_pop_c)             out_rem_d = out_rem_q - LEN_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) out_rem_q <= '0;
    else     out_rem_q <= out_rem_d;
  end

  assign out_last = !fifo_empty && (out_rem_q == LEN_W'(1));
`endif

endmodule

// File: doc/dpram_stream_reader.md
DPRAM_STREAM_READER -- requirements
Module: dpram_stream_reader

Interface
REQ-001 SHALL have parameter DATA_W, default 8, RAM word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, RAM address width in bits.
REQ-003 SHALL have parameter DEPTH, default 10, number of valid RAM words; addresses run 0..DEPTH-1.
REQ-004 SHALL have port clk  input  1  single clock for all logic, including the RAM read port.
REQ-005 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port start  input  1  one-cycle request to begin a burst.
REQ-007 SHALL have port base  input  ADDR_W  first RAM address of the burst, sampled with start.
REQ-008 SHALL have port len  input  ADDR_W+1  number of words in the burst, sampled with start.
REQ-009 SHALL have port busy  output  1  high from the cycle after start is accepted until done.
REQ-010 SHALL have port done  output  1  one-cycle pulse when the burst completes.
REQ-011 SHALL have port rd_en  output  1  RAM read enable.
REQ-012 SHALL have port rd_addr  output  ADDR_W  RAM read address.
REQ-013 SHALL have port rd_data  input  DATA_W  RAM read data, valid exactly 1 cycle after rd_en.
REQ-014 SHALL have port out_valid  output  1  stream data valid.
REQ-015 SHALL have port out_ready  input  1  stream sink ready.
REQ-016 SHALL have port out_data  output  DATA_W  stream data.

Function
REQ-017 SHALL implement FSM states IDLE, RUN, DRAIN, FIN: IDLE->RUN on accepted start with len>0; IDLE->FIN on start with len=0; RUN->DRAIN once len reads are issued; DRAIN->FIN once the buffer is empty and no read is in flight; FIN->IDLE unconditionally.
REQ-018 SHALL accept start only in IDLE; start in any other state SHALL be ignored without side effect.
REQ-019 SHALL assert rd_en with rd_addr=base in the cycle after start is accepted, then increment rd_addr by one per issued read.
REQ-020 SHALL wrap rd_addr from DEPTH-1 to 0, never presenting an address >= DEPTH.
REQ-021 SHALL buffer returned words in a 2-entry FIFO and SHALL issue a read only when (buffer occupancy + reads in flight) < 2, so no word is ever dropped.
REQ-022 SHALL drive out_valid/out_data from the FIFO head; once out_valid is high, out_valid and out_data SHALL stay stable until the cycle in which out_ready is high.
REQ-023 SHALL, with out_ready held high, present the first word at start-cycle+3 and then sustain one word per cycle.
REQ-024 SHALL emit words in address order, exactly len words per burst.
REQ-025 SHALL pulse done for one cycle in FIN; busy SHALL be low in FIN and IDLE.
REQ-026 SHALL accept len up to 2^ADDR_W; len > DEPTH SHALL re-read wrapped addresses.

Reset
REQ-027 SHALL, on rst, within one clock: state IDLE, busy=0, done=0, rd_en=0, rd_addr=0, out_valid=0, out_data=0, FIFO emptied.
REQ-028 SHALL discard any in-flight read when rst occurs mid-burst; no word appears after reset deassertion.

Configuration
REQ-029 SHALL, with macro DPRAM_STREAM_READER_LAST_EN defined, add output out_last (1 bit), high with the final word of each burst and qualified by out_valid, reset value 0.
REQ-030 SHALL, without DPRAM_STREAM_READER_LAST_EN, omit out_last and its logic entirely; all other behaviour unchanged.

Structure
REQ-031 SHALL place the FSM state enum and default DATA_W/ADDR_W/DEPTH constants in shared package dpram_stream_pkg.
REQ-032 SHALL implement the 2-entry buffer as sub-module stream_skid_fifo with push/pop/full/empty ports.

Verification
REQ-033 SHALL cover base=0, len=10, out_ready=1, RAM[i]=i -> out_data 0..9 on consecutive cycles, first valid at start+3, done one cycle after the last handshake.
REQ-034 SHALL cover base=7, len=6, DEPTH=10 -> rd_addr sequence 7,8,9,0,1,2 and matching out_data.
REQ-035 SHALL cover out_ready toggled 1,0,0,1 repeatedly with len=8 -> all 8 words delivered once, in order, data stable while stalled, at most 2 buffered.
REQ-036 SHALL cover start with len=0 -> no rd_en, no out_valid, done at start+1; and start while busy -> ignored.
REQ-037 SHALL cover rst asserted after 3 words of a len=10 burst -> all outputs at reset values next cycle, no further out_valid until a new start.
REQ-038 SHALL cover DPRAM_STREAM_READER_LAST_EN defined, len=4 -> out_last high only on the 4th word.
